// File: rtl/sort_frame_rx_if.sv
// sort_frame_rx_if: word stream from the sorter (in_vld/din) and drained
// word stream to the consumer (dout/dout_vld/rd_rdy).
// master = sorter/consumer side, slave = sort_frame_rx side.
interface sort_frame_rx_if;
  logic        in_vld;
  logic [15:0] din;
  logic        rd_rdy;
  logic [15:0] dout;
  logic        dout_vld;

  modport master (
    output in_vld, din, rd_rdy,
    input  dout, dout_vld
  );

  modport slave (
    input  in_vld, din, rd_rdy,
    output dout, dout_vld
  );
endinterface

// File: rtl/sort_frame_rx.sv
// sort_frame_rx: captures a 16-word sorted burst into a local buffer, records
// the frame max/min, then drains it over a valid/ready handshake.
// Optional feature macro: SORT_FRAME_RX_ORDER_CHECK_EN (signed non-increasing
// order check on captured words 1..15, reported on ord_err).
module sort_frame_rx (
  input  logic                  clk,
  input  logic                  rstn,
  sort_frame_rx_if.slave        bus,
  output logic                  frame_done,
  output logic [15:0]           max_o,
  output logic [15:0]           min_o,
  output logic                  frm_err,
  output logic                  ovf,
  output logic                  ord_err,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, CAPT, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [15:0] frame_buf [16];
  logic [3:0]  wcnt;
  logic [3:0]  rcnt;
  logic        cap_we;
  logic        last_word;
  logic        pop;
  logic [3:0]  wr_idx;

  // Decode the capture/drain events shared by the FSM and the datapath
  always_comb begin
    cap_we    = 1'b0;
    last_word = 1'b0;
    pop       = 1'b0;
    wr_idx    = '0;
    case (state)
      IDLE: begin
        cap_we = bus.in_vld;
        wr_idx = '0;
      end
      CAPT: begin
        cap_we    = bus.in_vld;
        wr_idx    = wcnt;
        last_word = bus.in_vld && (wcnt == 4'd15);
      end
      DRAIN: begin
        pop = bus.rd_rdy;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_vld) state_nxt = CAPT;
      CAPT: begin
        if (!bus.in_vld)   state_nxt = IDLE;
        else if (last_word) state_nxt = DRAIN;
      end
      DRAIN:   if (pop && (rcnt == 4'd15)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: drain handshake and busy; dout is a combinational buffer read
  always_comb begin
    bus.dout_vld = (state == DRAIN);
    busy         = (state != IDLE);
    bus.dout     = (state == DRAIN) ? frame_buf[rcnt] : '0;
  end

  // Buffer write and read/write counters
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < 16; i++) frame_buf[i] <= '0;
      wcnt <= '0;
      rcnt <= '0;
    end else begin
      if (cap_we) frame_buf[wr_idx] <= bus.din;
      case (state)
        IDLE: if (bus.in_vld) wcnt <= 4'd1;
        CAPT: begin
          if (bus.in_vld) wcnt <= wcnt + 4'd1;
          else            wcnt <= '0;
          if (last_word)  rcnt <= '0;
        end
        DRAIN: if (pop) rcnt <= rcnt + 4'd1;
        default: ;
      endcase
    end
  end

  // Frame completion pulse, max/min latch and sticky framing/overrun flags
  always_ff @(posedge clk) begin
    if (!rstn) begin
      frame_done <= 1'b0;
      max_o      <= '0;
      min_o      <= '0;
      frm_err    <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      frame_done <= last_word;
      if (last_word) begin
        max_o <= frame_buf[0];
        min_o <= bus.din;
      end
      if ((state == CAPT) && !bus.in_vld) frm_err <= 1'b1;
      if ((state == DRAIN) && bus.in_vld) ovf     <= 1'b1;
    end
  end

`ifdef SORT_FRAME_RX_ORDER_CHECK_EN
  logic [15:0] prev;
  logic [16:0] ord_diff;

  // prev - din as 17-bit signed; a negative result means din rose above prev
  always_comb begin
    ord_diff = {prev[15], prev} - {bus.din[15], bus.din};
  end

  // Track last captured word and flag any increase within a frame
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prev    <= '0;
      ord_err <= 1'b0;
    end else begin
      if (cap_we) prev <= bus.din;
      if ((state == CAPT) && bus.in_vld && ord_diff[16]) ord_err <= 1'b1;
    end
  end
`else
  assign ord_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_frame_rx.sv
// tb_sort_frame_rx: directed stimulus with a scoreboard queue; a negedge
// monitor compares every presented dout against the expected word stream.
module tb_sort_frame_rx;

  logic        clk;
  logic        rstn;
  logic        frame_done;
  logic [15:0] max_o;
  logic [15:0] min_o;
  logic        frm_err;
  logic        ovf;
  logic        ord_err;
  logic        busy;

  sort_frame_rx_if bus ();

  sort_frame_rx dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .frame_done (frame_done),
    .max_o      (max_o),
    .min_o      (min_o),
    .frm_err    (frm_err),
    .ovf        (ovf),
    .ord_err    (ord_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SORT_FRAME_RX_ORDER_CHECK_EN
  localparam int ORD_EXP = 1;
`else
  localparam int ORD_EXP = 0;
`endif

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          fd_cnt   = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp_max = '0;
  logic [15:0] exp_min = '0;

  logic [15:0] frm_a [16] = '{16'h6264, 16'h5555, 16'h5261, 16'h5000,
                              16'h2222, 16'h2001, 16'h1234, 16'h1111,
                              16'h1101, 16'h0000, 16'hFFFF, 16'hFFF0,
                              16'hF264, 16'hAAAA, 16'h9999, 16'h8888};
  logic [15:0] frm_b [16] = '{16'h7FFF, 16'h7000, 16'h6000, 16'h5000,
                              16'h4000, 16'h3000, 16'h2000, 16'h1000,
                              16'h0800, 16'h0001, 16'h0000, 16'hFFFF,
                              16'hFF00, 16'hC000, 16'h8001, 16'h8000};
  logic [15:0] frm_s [16] = '{16'h6264, 16'h5555, 16'h5261, 16'h5000,
                              16'h2001, 16'h2222, 16'h1234, 16'h1111,
                              16'h1101, 16'h0000, 16'hFFFF, 16'hFFF0,
                              16'hF264, 16'hAAAA, 16'h9999, 16'h8888};

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every presented word must match the queue head;
  // a word is consumed only when rd_rdy accepts it.
  always @(negedge clk) begin
    if (frame_done) begin
      fd_cnt++;
      check("max_o", int'(max_o), int'(exp_max));
      check("min_o", int'(min_o), int'(exp_min));
    end
    if (bus.dout_vld) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_word: got %0h expected none", bus.dout);
      end else begin
        check("dout", int'(bus.dout), int'(exp_q[0]));
        if (bus.rd_rdy) void'(exp_q.pop_front());
      end
    end
  end

  // Drive one 16-word burst; expected words are queued at issue time
  task automatic send_frame(input logic [15:0] w [16], input int ord_chk);
    for (int i = 0; i < 16; i++) exp_q.push_back(w[i]);
    exp_max = w[0];
    exp_min = w[15];
    for (int i = 0; i < 16; i++) begin
      bus.din    = w[i];
      bus.in_vld = 1'b1;
      @(posedge clk); #1;
      if (ord_chk != 0 && i == 4) check("ord_err_w4", int'(ord_err), 0);
      if (ord_chk != 0 && i == 5) check("ord_err_w5", int'(ord_err), ORD_EXP);
    end
    bus.in_vld = 1'b0;
    bus.din    = '0;
    check("frame_done_pulse", int'(frame_done), 1);
  endtask

  // Drain with a repeating 4-cycle rd_rdy pattern; reports cycles until idle
  task automatic drain(input logic [3:0] pat, output int cyc);
    cyc = 0;
    for (int k = 0; k < 200; k++) begin
      bus.rd_rdy = pat[k % 4];
      @(posedge clk); #1;
      cyc++;
      if (!busy) break;
    end
    if (busy) begin
      chk_cnt++;
      $display("FAIL drain_timeout: busy still %0b after %0d cycles", busy, cyc);
    end
    bus.rd_rdy = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int fd0;
    rstn       = 1'b0;
    bus.in_vld = 1'b0;
    bus.din    = '0;
    bus.rd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout_vld", int'(bus.dout_vld), 0);
    check("rst_dout", int'(bus.dout), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_max", int'(max_o), 0);
    check("rst_min", int'(min_o), 0);
    check("rst_frm_err", int'(frm_err), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_ord_err", int'(ord_err), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Full frame, full-rate drain
    bus.rd_rdy = 1'b1;
    fd0 = fd_cnt;
    send_frame(frm_a, 0);
    drain(4'b1111, cyc);
    check("drain_cycles", cyc, 16);
    check("frame_done_count", fd_cnt - fd0, 1);
    check("queue_empty_full", exp_q.size(), 0);
    check("ord_err_clean", int'(ord_err), 0);
    check("idle_after_drain", int'(busy), 0);

    // Backpressure: rd_rdy 1,0,0,1 repeating
    send_frame(frm_a, 0);
    drain(4'b1001, cyc);
    check("bp_cycles", cyc, 32);
    check("queue_empty_bp", exp_q.size(), 0);

    // Short burst of 9 words
    fd0 = fd_cnt;
    for (int i = 0; i < 9; i++) begin
      bus.din    = 16'h7000 - 16'(i);
      bus.in_vld = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_vld = 1'b0;
    @(posedge clk); #1;
    check("short_frm_err", int'(frm_err), 1);
    check("short_busy", int'(busy), 0);
    check("short_max_kept", int'(max_o), 16'h6264);
    check("short_min_kept", int'(min_o), 16'h8888);
    check("short_no_done", fd_cnt - fd0, 0);
    send_frame(frm_b, 0);
    drain(4'b1111, cyc);
    check("after_short_cycles", cyc, 16);
    check("queue_empty_short", exp_q.size(), 0);

    // Overrun while draining is stalled
    check("ovf_clear", int'(ovf), 0);
    bus.rd_rdy = 1'b0;
    send_frame(frm_a, 0);
    bus.din    = 16'h1234;
    bus.in_vld = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
    bus.din    = '0;
    check("ovf_set", int'(ovf), 1);
    check("ovf_dout_held", int'(bus.dout), 16'h6264);
    check("ovf_still_draining", int'(bus.dout_vld), 1);
    drain(4'b1111, cyc);
    check("queue_empty_ovf", exp_q.size(), 0);

    // Order violation: words 4 and 5 swapped
    check("ord_err_before", int'(ord_err), 0);
    bus.rd_rdy = 1'b1;
    send_frame(frm_s, 1);
    drain(4'b1111, cyc);
    check("ord_err_sticky", int'(ord_err), ORD_EXP);
    check("queue_empty_ord", exp_q.size(), 0);

    // Reset after 5 pops
    send_frame(frm_b, 0);
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_remaining", exp_q.size(), 11);
    bus.rd_rdy = 1'b0;
    rstn       = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_q.delete();
    check("rmid_dout_vld", int'(bus.dout_vld), 0);
    check("rmid_dout", int'(bus.dout), 0);
    check("rmid_busy", int'(busy), 0);
    check("rmid_frame_done", int'(frame_done), 0);
    check("rmid_max", int'(max_o), 0);
    check("rmid_min", int'(min_o), 0);
    check("rmid_frm_err", int'(frm_err), 0);
    check("rmid_ovf", int'(ovf), 0);
    check("rmid_ord_err", int'(ord_err), 0);
    bus.rd_rdy = 1'b1;
    send_frame(frm_a, 0);
    drain(4'b1111, cyc);
    check("post_rst_cycles", cyc, 16);
    check("queue_empty_post_rst", exp_q.size(), 0);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
